// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: owns mepc/mcause/mtval/mstatus, arbitrates exceptions, mret and interrupts.
// Optional TRAP_VECTORED_EN: interrupt traps use base + 4*code when mtvec mode bits are 2'b01.
module trap_ctrl #(
   parameter int XLEN      = 64,
   parameter int LOCAL_IRQ = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 exc_valid,
   input  logic [5:0]           exc_cause,
   input  logic [XLEN-1:0]      exc_pc,
   input  logic [XLEN-1:0]      exc_tval,
   input  logic                 mret_valid,
   input  logic                 int_ok,
   input  logic [XLEN-1:0]      int_pc,
   input  logic                 irq_ext,
   input  logic                 irq_tmr,
   input  logic                 irq_sft,
   input  logic [LOCAL_IRQ-1:0] irq_local,
   input  logic [XLEN-1:0]      mie_csr,
   input  logic [XLEN-1:0]      mtvec_csr,
   input  logic                 csr_we,
   input  logic [11:0]          csr_addr,
   input  logic [XLEN-1:0]      csr_wdata,
   output logic [XLEN-1:0]      mepc_out,
   output logic [XLEN-1:0]      mcause_out,
   output logic [XLEN-1:0]      mtval_out,
   output logic [XLEN-1:0]      mstatus_out,
   output logic [XLEN-1:0]      mip_out,
   output logic                 busy,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   input  logic                 redirect_ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TRAP = 2'd1,
      ST_RET  = 2'd2
   } state_t;

   state_t            state_r;
   logic [XLEN-1:0]   mepc_r;
   logic [XLEN-1:0]   mcause_r;
   logic [XLEN-1:0]   mtval_r;
   logic              mie_bit_r;
   logic              mpie_r;
   logic [XLEN-1:0]   mip_r;
   logic              busy_r;
   logic              redirect_valid_r;
   logic [XLEN-1:0]   redirect_pc_r;

   logic [XLEN-1:0]   mip_s;
   logic [XLEN-1:0]   en_s;
   logic              irq_take_s;
   logic [5:0]        irq_code_s;
   logic [XLEN-1:0]   base_s;
   logic [XLEN-1:0]   irq_target_s;

   // Lowest-priority candidates are visited first so higher ones overwrite them.
   function automatic logic [5:0] irq_code(input logic [XLEN-1:0] en);
      logic [5:0] c;
      c = 6'd0;
      for (int i = LOCAL_IRQ - 1; i >= 0; i--) begin
         if (en[16+i]) c = 6'(16 + i);
         else          c = c;
      end
      if (en[7])  c = 6'd7;  else c = c;
      if (en[3])  c = 6'd3;  else c = c;
      if (en[11]) c = 6'd11; else c = c;
      return c;
   endfunction

   // Raw interrupt levels mapped onto their mip bit positions.
   always_comb begin
      mip_s     = {XLEN{1'b0}};
      mip_s[11] = irq_ext;
      mip_s[7]  = irq_tmr;
      mip_s[3]  = irq_sft;
      for (int i = 0; i < LOCAL_IRQ; i++) begin
         mip_s[16+i] = irq_local[i];
      end
   end

   // Interrupt candidate selection and trap target computation.
   always_comb begin
      en_s         = mip_r & mie_csr;
      irq_take_s   = mie_bit_r & (|en_s);
      irq_code_s   = irq_code(en_s);
      base_s       = {mtvec_csr[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
      if (mtvec_csr[1:0] == 2'b01) begin
         irq_target_s = base_s + {{(XLEN-8){1'b0}}, irq_code_s, 2'b00};
      end else begin
         irq_target_s = base_s;
      end
`else
      irq_target_s = base_s;
`endif
   end

`ifndef TRAP_VECTORED_EN
   logic unused_mode_s;
   assign unused_mode_s = ^mtvec_csr[1:0];
`endif

   // Controller state, owned CSRs and the redirect request.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r          <= ST_IDLE;
         mepc_r           <= {XLEN{1'b0}};
         mcause_r         <= {XLEN{1'b0}};
         mtval_r          <= {XLEN{1'b0}};
         mie_bit_r        <= 1'b0;
         mpie_r           <= 1'b0;
         mip_r            <= {XLEN{1'b0}};
         busy_r           <= 1'b0;
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= {XLEN{1'b0}};
      end else begin
         mip_r <= mip_s;
         // Software writes first; a trap/mret update below overrides the same field.
         if (csr_we) begin
            case (csr_addr)
               12'h341: mepc_r   <= {csr_wdata[XLEN-1:2], 2'b00};
               12'h342: mcause_r <= csr_wdata;
               12'h343: mtval_r  <= csr_wdata;
               12'h300: begin
                  mie_bit_r <= csr_wdata[3];
                  mpie_r    <= csr_wdata[7];
               end
               default: ;
            endcase
         end
         case (state_r)
            ST_IDLE: begin
               if (exc_valid) begin
                  mepc_r           <= exc_pc;
                  mcause_r         <= {{(XLEN-6){1'b0}}, exc_cause};
                  mtval_r          <= exc_tval;
                  mpie_r           <= mie_bit_r;
                  mie_bit_r        <= 1'b0;
                  redirect_pc_r    <= base_s;
                  redirect_valid_r <= 1'b1;
                  busy_r           <= 1'b1;
                  state_r          <= ST_TRAP;
               end else if (mret_valid) begin
                  mie_bit_r        <= mpie_r;
                  mpie_r           <= 1'b1;
                  redirect_pc_r    <= mepc_r;
                  redirect_valid_r <= 1'b1;
                  busy_r           <= 1'b1;
                  state_r          <= ST_RET;
               end else if (int_ok && irq_take_s) begin
                  mepc_r           <= int_pc;
                  mcause_r         <= {1'b1, {(XLEN-7){1'b0}}, irq_code_s};
                  mtval_r          <= {XLEN{1'b0}};
                  mpie_r           <= mie_bit_r;
                  mie_bit_r        <= 1'b0;
                  redirect_pc_r    <= irq_target_s;
                  redirect_valid_r <= 1'b1;
                  busy_r           <= 1'b1;
                  state_r          <= ST_TRAP;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_TRAP, ST_RET: begin
               if (redirect_ready) begin
                  redirect_valid_r <= 1'b0;
                  busy_r           <= 1'b0;
                  state_r          <= ST_IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               redirect_valid_r <= 1'b0;
               busy_r           <= 1'b0;
               state_r          <= ST_IDLE;
            end
         endcase
      end
   end

   // mstatus view: MPP hardwired to machine mode, only MIE/MPIE live.
   always_comb begin
      mstatus_out     = {XLEN{1'b0}};
      mstatus_out[12] = 1'b1;
      mstatus_out[11] = 1'b1;
      mstatus_out[7]  = mpie_r;
      mstatus_out[3]  = mie_bit_r;
   end

   assign mepc_out       = mepc_r;
   assign mcause_out     = mcause_r;
   assign mtval_out      = mtval_r;
   assign mip_out        = mip_r;
   assign busy           = busy_r;
   assign redirect_valid = redirect_valid_r;
   assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl (default XLEN=64, LOCAL_IRQ=4).
module tb_trap_ctrl;

   localparam int XLEN = 64;
   localparam int LIRQ = 4;

   logic            CLK = 1'b0;
   logic            RST;
   logic            exc_valid, mret_valid, int_ok;
   logic [5:0]      exc_cause;
   logic [XLEN-1:0] exc_pc, exc_tval, int_pc, mie_csr, mtvec_csr, csr_wdata;
   logic            irq_ext, irq_tmr, irq_sft;
   logic [LIRQ-1:0] irq_local;
   logic            csr_we;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] mepc_out, mcause_out, mtval_out, mstatus_out, mip_out, redirect_pc;
   logic            busy, redirect_valid, redirect_ready;

   int checks   = 0;
   int failures = 0;

   trap_ctrl #(.XLEN(XLEN), .LOCAL_IRQ(LIRQ)) dut (
      .CLK(CLK), .RST(RST),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .mret_valid(mret_valid), .int_ok(int_ok), .int_pc(int_pc),
      .irq_ext(irq_ext), .irq_tmr(irq_tmr), .irq_sft(irq_sft), .irq_local(irq_local),
      .mie_csr(mie_csr), .mtvec_csr(mtvec_csr),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .mepc_out(mepc_out), .mcause_out(mcause_out), .mtval_out(mtval_out),
      .mstatus_out(mstatus_out), .mip_out(mip_out), .busy(busy),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready)
   );

   always #5 CLK = ~CLK;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then settle past it before anyone samples or drives.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
      csr_we = 1'b1; csr_addr = a; csr_wdata = d;
      step();
      csr_we = 1'b0;
   endtask

   task automatic handshake();
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      exc_valid = 1'b0; mret_valid = 1'b0; int_ok = 1'b0;
      exc_cause = 6'd0; exc_pc = 64'd0; exc_tval = 64'd0; int_pc = 64'd0;
      irq_ext = 1'b0; irq_tmr = 1'b0; irq_sft = 1'b0; irq_local = 4'b0000;
      mie_csr = 64'd0; mtvec_csr = 64'h8000_0100;
      csr_we = 1'b0; csr_addr = 12'h000; csr_wdata = 64'd0; redirect_ready = 1'b0;
      step(); step();
      RST = 1'b0;
      check_value("rst_mstatus", mstatus_out, 64'h1800);
      check_value("rst_mepc", mepc_out, 64'd0);
      check_value("rst_rvalid", {63'd0, redirect_valid}, 64'd0);
      check_value("rst_busy", {63'd0, busy}, 64'd0);
      check_value("rst_mip", mip_out, 64'd0);

      csr_write(12'h300, 64'h8);
      check_value("sw_mie", mstatus_out, 64'h1808);

      // Exception
      exc_valid = 1'b1; exc_cause = 6'd2; exc_pc = 64'h8000_0010; exc_tval = 64'hDEAD;
      step();
      exc_valid = 1'b0;
      check_value("exc_rvalid", {63'd0, redirect_valid}, 64'd1);
      check_value("exc_rpc", redirect_pc, 64'h8000_0100);
      check_value("exc_mepc", mepc_out, 64'h8000_0010);
      check_value("exc_mcause", mcause_out, 64'd2);
      check_value("exc_mtval", mtval_out, 64'hDEAD);
      check_value("exc_mstatus", mstatus_out, 64'h1880);

      // Stall: second exception ignored while busy
      exc_valid = 1'b1; exc_cause = 6'd5; exc_pc = 64'h123; exc_tval = 64'h9;
      for (int i = 0; i < 3; i++) begin
         step();
         check_value("hold_rvalid", {63'd0, redirect_valid}, 64'd1);
         check_value("hold_rpc", redirect_pc, 64'h8000_0100);
         check_value("hold_busy", {63'd0, busy}, 64'd1);
         check_value("hold_mcause", mcause_out, 64'd2);
      end
      exc_valid = 1'b0;
      handshake();
      check_value("hs_busy", {63'd0, busy}, 64'd0);
      check_value("hs_rvalid", {63'd0, redirect_valid}, 64'd0);

      // Interrupt priority
      csr_write(12'h300, 64'h88);
      check_value("sw_mstatus", mstatus_out, 64'h1888);
      irq_tmr = 1'b1; irq_ext = 1'b1; irq_local = 4'b0001; mie_csr = {64{1'b1}};
      step();
      check_value("mip_sync", mip_out, 64'h0001_0880);
      check_value("no_int_ok_busy", {63'd0, busy}, 64'd0);
      int_ok = 1'b1; int_pc = 64'h8000_0040;
      step();
      int_ok = 1'b0;
      check_value("irq_mcause", mcause_out, 64'h8000_0000_0000_000B);
      check_value("irq_mepc", mepc_out, 64'h8000_0040);
      check_value("irq_mtval", mtval_out, 64'd0);
      check_value("irq_rpc", redirect_pc, 64'h8000_0100);
      check_value("irq_mstatus", mstatus_out, 64'h1880);
      handshake();

      // mret, then pending MEI retaken after handshake
      mret_valid = 1'b1;
      step();
      mret_valid = 1'b0;
      check_value("mret_rpc", redirect_pc, 64'h8000_0040);
      check_value("mret_mstatus", mstatus_out, 64'h1888);
      check_value("mret_rvalid", {63'd0, redirect_valid}, 64'd1);
      int_ok = 1'b1; int_pc = 64'h8000_0044;
      handshake();
      check_value("mret_idle", {63'd0, busy}, 64'd0);
      step();
      int_ok = 1'b0;
      check_value("retake_busy", {63'd0, busy}, 64'd1);
      check_value("retake_mepc", mepc_out, 64'h8000_0044);
      check_value("retake_mcause", mcause_out, 64'h8000_0000_0000_000B);
      handshake();

      // Simultaneous exception + mret + interrupt + sw mepc write
      csr_write(12'h300, 64'h8);
      exc_valid = 1'b1; exc_cause = 6'd4; exc_pc = 64'h2000; exc_tval = 64'h77;
      mret_valid = 1'b1; int_ok = 1'b1; int_pc = 64'h3000;
      csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 64'h1003;
      step();
      exc_valid = 1'b0; mret_valid = 1'b0; int_ok = 1'b0; csr_we = 1'b0;
      check_value("sim_mcause", mcause_out, 64'd4);
      check_value("sim_mepc", mepc_out, 64'h2000);
      check_value("sim_rpc", redirect_pc, 64'h8000_0100);
      handshake();
      csr_write(12'h341, 64'h1003);
      check_value("sw_mepc", mepc_out, 64'h1000);
      csr_write(12'h343, 64'hFFFF_0000_1234_5677);
      check_value("sw_mtval", mtval_out, 64'hFFFF_0000_1234_5677);

      // Deasserted levels are never taken
      irq_ext = 1'b0; irq_tmr = 1'b0; irq_local = 4'b0000;
      step(); step();
      csr_write(12'h300, 64'h8);
      int_ok = 1'b1;
      step(); step();
      int_ok = 1'b0;
      check_value("gone_busy", {63'd0, busy}, 64'd0);
      check_value("gone_mip", mip_out, 64'd0);

      // Vectored MTI
      mtvec_csr = 64'h8000_0101; irq_tmr = 1'b1;
      step();
      int_ok = 1'b1; int_pc = 64'h5000;
      step();
      int_ok = 1'b0;
      check_value("vec_mcause", mcause_out, 64'h8000_0000_0000_0007);
`ifdef TRAP_VECTORED_EN
      check_value("vec_rpc", redirect_pc, 64'h8000_011C);
`else
      check_value("vec_rpc", redirect_pc, 64'h8000_0100);
`endif

      // Reset in the middle of a redirect
      irq_tmr = 1'b0;
      RST = 1'b1;
      step();
      RST = 1'b0;
      check_value("mrst_rvalid", {63'd0, redirect_valid}, 64'd0);
      check_value("mrst_busy", {63'd0, busy}, 64'd0);
      check_value("mrst_mepc", mepc_out, 64'd0);
      check_value("mrst_mcause", mcause_out, 64'd0);
      check_value("mrst_mstatus", mstatus_out, 64'h1800);
      check_value("mrst_rpc", redirect_pc, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap controller; successor to the combinational trap-detect logic.
- Owns mepc/mcause/mtval/mstatus(MIE,MPIE,MPP).
- Arbitrates committed exceptions, mret and prioritised interrupts (3 standard + LOCAL_IRQ platform lines).
- Drives a pc redirect to the frontend through a valid/ready handshake.
- Sits between the commit stage, the CSR file and the fetch redirect path.

Parameters:
XLEN, 64, datapath width of pc and trap CSRs
LOCAL_IRQ, 4, platform interrupt lines at mip/mie bits 16..16+LOCAL_IRQ-1 (1..16)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
exc_valid  in  1  committed instruction raised exception
exc_cause  in  6  exception code
exc_pc  in  XLEN  faulting pc
exc_tval  in  XLEN  trap value
mret_valid  in  1  committed mret
int_ok  in  1  commit boundary where interrupt may be taken
int_pc  in  XLEN  pc of next uncommitted instruction
irq_ext/irq_tmr/irq_sft  in  1 each  raw MEIP/MTIP/MSIP levels
irq_local  in  LOCAL_IRQ  raw platform interrupt levels
mie_csr  in  XLEN  mie value from CSR file
mtvec_csr  in  XLEN  mtvec value from CSR file
csr_we  in  1  software CSR write strobe
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  CSR write data
mepc_out/mcause_out/mtval_out/mstatus_out  out  XLEN  owned CSR values
mip_out  out  XLEN  registered pending bits
busy  out  1  controller not IDLE; upstream must hold events
redirect_valid  out  1  redirect request
redirect_pc  out  XLEN  target pc
redirect_ready  in  1  frontend accepts redirect

Behaviour:
- Clock/reset: single clock CLK; reset RST is synchronous and active-high.
- Reset values: state IDLE, mepc=mcause=mtval=0, MIE=0, MPIE=0, MPP=2'b11 (hardwired), mip_out=0, redirect_valid=0, redirect_pc=0, busy=0.
- mip_out:
  - Bit 11 registers irq_ext, bit 7 irq_tmr, bit 3 irq_sft, bits 16+i irq_local[i]; all other bits 0.
  - One cycle of synchronisation; pending evaluation uses mip_out.
- Enabled pending: en = mip_out & mie_csr; interrupt candidate iff MIE=1 and en != 0.
- Interrupt priority: 11 > 3 > 7 > local 16 > 17 > ... (lowest index wins).
- States: IDLE, TRAP, RET.
- IDLE, in a given cycle, priority order:
  - exc_valid: mepc<=exc_pc, mcause<={0,exc_cause}, mtval<=exc_tval, MPIE<=MIE, MIE<=0, redirect_pc<=trap target, go TRAP.
  - else mret_valid: MIE<=MPIE, MPIE<=1, redirect_pc<=mepc, go RET.
  - else int_ok and interrupt candidate: mepc<=int_pc, mcause<={1,code}, mtval<=0, MPIE<=MIE, MIE<=0, go TRAP.
- Trap target = {mtvec_csr[XLEN-1:2],2'b00}.
- Latency: event in cycle N -> CSRs updated at edge N, redirect_valid=1 from N+1.
- TRAP/RET: hold redirect_valid and redirect_pc stable until redirect_ready=1, then go IDLE.
  - Events presented while busy=1 are ignored (not queued).
- Software CSR writes (csr_we, accepted in any state):
  - 0x341 mepc: bits[1:0] forced 0.
  - 0x342 mcause: full width.
  - 0x343 mtval: full width.
  - 0x300 mstatus: only MIE(3) and MPIE(7) writable.
  - A trap/mret update in the same cycle wins over the software write to the same field.
- mret followed by a pending interrupt: MIE is restored at edge N, so the interrupt is eligible in the first IDLE cycle after the redirect handshake.
- Level interrupts deasserted before being taken are never taken.
- RST mid-redirect: drops the request; registers return to reset values.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: when mtvec_csr[1:0]==2'b01 and the trap is an interrupt, target = base + 4*code; exceptions still use base.
- Undefined: mtvec mode bits are ignored; all traps go to base.

Test Plan:
1. Exception: exc_valid, exc_cause=2, exc_pc=0x8000_0010, tval=0xDEAD, mtvec=0x8000_0100, MIE=1 -> next cycle redirect_valid=1, redirect_pc=0x8000_0100, mepc=0x8000_0010, mcause=2, mtval=0xDEAD, MIE=0, MPIE=1.
2. Handshake: hold redirect_ready=0 for 3 cycles -> redirect_valid/pc stable, busy=1, a second exc_valid is ignored; ready=1 -> IDLE the next cycle.
3. Priority: irq_tmr=irq_ext=irq_local[0]=1, mie all enabled, MIE=1, int_ok, int_pc=0x8000_0040 -> mcause=0x8000_0000_0000_000B, mepc=0x8000_0040.
4. mret: after test 3, mret_valid -> redirect_pc=0x8000_0040, MIE=1, MPIE=1; the still-pending MEI is taken again after the handshake.
5. Simultaneous: exc_valid+mret_valid+pending interrupt in one cycle -> exception taken. CSR write of mepc=0x1003 in the same cycle as the trap -> mepc holds the trap pc. Alone -> mepc reads 0x1000.
6. TRAP_VECTORED_EN: mtvec=0x8000_0101, MTI taken -> redirect_pc=0x8000_011C. Macro undefined -> 0x8000_0100.
